id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
Decode stage of the toothless core and the producer side of the ALU operator/operand interface. Accepts a fetched RV32I instruction over a valid/ready handshake and reads rs1/rs2 from the register file. It decodes the instruction into an alu_opcode_e operator plus both operands, and registers the result into a single pipeline slot toward the execute stage. Covers the OP, OP-IMM, LUI, AUIPC and BRANCH opcode classes; any other instruction is flagged illegal.

Parameters:
DATA_WIDTH, 32, operand, PC and instruction width.
REG_ADDR_WIDTH, 5, register-file address width.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
instr_valid_i  in  1  fetch holds a valid instruction
instr_ready_o  out  1  stage can accept an instruction this cycle
instr_i  in  DATA_WIDTH  instruction word
pc_i  in  DATA_WIDTH  PC of instr_i
rs1_addr_o  out  REG_ADDR_WIDTH  regfile read address 1, combinational from instr_i[19:15]
rs2_addr_o  out  REG_ADDR_WIDTH  regfile read address 2, combinational from instr_i[24:20]
rs1_data_i  in  DATA_WIDTH  combinational read data 1
rs2_data_i  in  DATA_WIDTH  combinational read data 2
flush_i  in  1  discard the slot content and any instruction accepted this cycle
ex_valid_o  out  1  slot holds a decoded instruction
ex_ready_i  in  1  execute consumes the slot
alu_operator_o  out  alu_opcode_e  ALU operation
alu_operand_a_o  out  DATA_WIDTH  ALU operand A
alu_operand_b_o  out  DATA_WIDTH  ALU operand B
rd_addr_o  out  REG_ADDR_WIDTH  destination register
rd_we_o  out  1  write-back enable
branch_o  out  1  conditional branch; ALU result bit 0 is the taken flag
branch_target_o  out  DATA_WIDTH  pc plus B-immediate
illegal_instr_o  out  1  undecodable instruction

Behaviour:
- Reset (asynchronous, rst_n low): ex_valid_o=0. All registered outputs are 0, and alu_operator_o=ALU_ADD. Reset asserted mid-handshake drops the slot content.
- instr_ready_o = !ex_valid_o || ex_ready_i. This is combinational; it does not depend on instr_valid_i.
- Accept when instr_valid_i && instr_ready_o. The slot loads on the next clk edge, so latency is 1 cycle from accept to ex_valid_o.
- ex_valid_o next value: accept ? 1 : (ex_ready_i ? 0 : hold). Back-to-back throughput is 1 instruction per cycle.
- While ex_valid_o && !ex_ready_i, every slot output holds stable.
- flush_i has priority. On the next cycle ex_valid_o=0, and an instruction accepted in the same cycle is dropped. It still counts as consumed by fetch.
- Operand A:
  - rs1_data_i for OP, OP-IMM and BRANCH.
  - 0 for LUI.
  - pc_i for AUIPC.
- Operand B:
  - OP-IMM non-shift: sign-extended I-immediate.
  - Immediate shifts: zero-extended shamt instr[24:20].
  - OP register shifts: rs2_data_i & 0x1F, i.e. upper 27 bits forced to zero.
  - OP non-shift and BRANCH: rs2_data_i.
  - LUI and AUIPC: {instr[31:12], 12'b0}.
- Operator mapping:
  - ADD/ADDI/LUI/AUIPC -> ALU_ADD; SUB -> ALU_SUB.
  - AND/OR/XOR (and the I forms) -> ALU_AND, ALU_OR, ALU_XOR.
  - SLL/SRL/SRA (and the I forms) -> ALU_SLL, ALU_SRL, ALU_SRA.
  - SLT(I)/SLTU/SLTIU -> ALU_SLT, ALU_SLTU.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU -> ALU_EQ, ALU_NE, ALU_SLT, ALU_GES, ALU_SLTU, ALU_GEU.
- Illegal cases:
  - unknown opcode;
  - funct7 other than 0x00 or 0x20, or 0x20 on a non-SUB/SRA op;
  - SLLI/SRLI/SRAI with an illegal funct7;
  - branch funct3 of 2 or 3.
  - An illegal instruction passes through with illegal_instr_o=1, operator ALU_ADD, rd_we_o=0 and branch_o=0.
- rd_we_o=1 only for legal OP/OP-IMM/LUI/AUIPC with rd!=0. BRANCH gives rd_we_o=0 and branch_o=1.

Decomposition:
- toothless_pkg gains:
  - RV32I opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH);
  - funct3/funct7 constants;
  - an imm_sel_e enum (IMM_I, IMM_SHAMT, IMM_U, IMM_B).
- alu_opcode_e is reused unchanged.
- One combinational sub-module, id_decoder, maps instruction to operator, operand selects, immediates, rd_we, branch and illegal.
- id_stage itself owns the handshake, the operand muxes and the pipeline register.

Test Plan:
1. ADDI x5,x1,-3 (0xFFD08293), rs1=10, ex_ready_i=1 -> next cycle: ex_valid_o=1, ALU_ADD, a=0x0000000A, b=0xFFFFFFFD, rd=5, rd_we_o=1.
2. SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=9 -> ALU_SUB, a=7, b=9, rd=3. Then SRAI x6,x7,4 (0x4043D313) -> ALU_SRA, b=4. Then SLL with rs2=0x123 -> ALU_SLL, b=0x3.
3. LUI x1,0x12345 (0x123450B7) -> a=0, b=0x12345000, ALU_ADD. AUIPC with pc=0x100 and the same immediate -> a=0x100.
4. BEQ x1,x2,+8 (0x00208463) at pc=0x40 -> ALU_EQ, branch_o=1, rd_we_o=0, branch_target_o=0x48.
5. Slot full with ex_ready_i=0 for 3 cycles while a new instruction is presented -> instr_ready_o=0 and outputs unchanged. Raise ex_ready_i -> accepted and the new decode appears the next cycle.
6. Exceptional inputs:
   - instr 0xFFFFFFFF -> illegal_instr_o=1, rd_we_o=0.
   - flush_i in the same cycle as an accept -> ex_valid_o=0 next cycle.
   - rst_n low mid-stream -> ex_valid_o=0 immediately.

Source files
------------

// File: rtl/toothless_pkg.sv
// Shared types and RV32I encoding constants for the toothless core.
package toothless_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10,
    ALU_NE   = 4'd11,
    ALU_GES  = 4'd12,
    ALU_GEU  = 4'd13
  } alu_opcode_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {IMM_I, IMM_SHAMT, IMM_U, IMM_B} imm_sel_e;
  typedef enum logic [1:0] {OPA_RS1, OPA_ZERO, OPA_PC} op_a_sel_e;
  typedef enum logic [1:0] {OPB_RS2, OPB_RS2_SHAMT, OPB_IMM} op_b_sel_e;

  typedef struct packed {
    alu_opcode_e op;
    op_a_sel_e   a_sel;
    op_b_sel_e   b_sel;
    imm_sel_e    imm_sel;
    logic        rd_we;
    logic        branch;
    logic        illegal;
  } id_dec_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: operator, operand selects, immediates and legality.
module id_decoder
  import toothless_pkg::*;
(
  input  logic [XLEN-1:0] i_instr,
  output id_dec_t         o_dec,
  output logic [XLEN-1:0] o_imm,
  output logic [XLEN-1:0] o_imm_b
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_rd_nz;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_imm_sh;

  assign w_opc    = i_instr[6:0];
  assign w_f3     = i_instr[14:12];
  assign w_f7     = i_instr[31:25];
  assign w_rd_nz  = (i_instr[11:7] != 5'd0);
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_sh = {27'b0, i_instr[24:20]};
  assign o_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};

  // Shared funct3 -> operator table for OP and OP-IMM; SUB/SRA patched by caller
  function automatic alu_opcode_e arith_op(input logic [2:0] f3);
    case (f3)
      F3_ADD_SUB: arith_op = ALU_ADD;
      F3_SLL:     arith_op = ALU_SLL;
      F3_SLT:     arith_op = ALU_SLT;
      F3_SLTU:    arith_op = ALU_SLTU;
      F3_XOR:     arith_op = ALU_XOR;
      F3_SRL_SRA: arith_op = ALU_SRL;
      F3_OR:      arith_op = ALU_OR;
      default:    arith_op = ALU_AND;
    endcase
  endfunction

  always_comb begin
    o_dec         = '0;
    o_dec.op      = ALU_ADD;
    o_dec.a_sel   = OPA_RS1;
    o_dec.b_sel   = OPB_RS2;
    o_dec.imm_sel = IMM_I;
    case (w_opc)
      OPC_OP: begin
        o_dec.op    = arith_op(w_f3);
        o_dec.rd_we = w_rd_nz;
        if (w_f3 == F3_SLL || w_f3 == F3_SRL_SRA) o_dec.b_sel = OPB_RS2_SHAMT;
        if (w_f7 == F7_ALT) begin
          if (w_f3 == F3_ADD_SUB)      o_dec.op = ALU_SUB;
          else if (w_f3 == F3_SRL_SRA) o_dec.op = ALU_SRA;
          else                         o_dec.illegal = 1'b1;
        end else if (w_f7 != F7_BASE) begin
          o_dec.illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        o_dec.op    = arith_op(w_f3);
        o_dec.b_sel = OPB_IMM;
        o_dec.rd_we = w_rd_nz;
        if (w_f3 == F3_SLL) begin
          o_dec.imm_sel = IMM_SHAMT;
          if (w_f7 != F7_BASE) o_dec.illegal = 1'b1;
        end else if (w_f3 == F3_SRL_SRA) begin
          o_dec.imm_sel = IMM_SHAMT;
          if (w_f7 == F7_ALT)       o_dec.op = ALU_SRA;
          else if (w_f7 != F7_BASE) o_dec.illegal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        o_dec.a_sel   = (w_opc == OPC_LUI) ? OPA_ZERO : OPA_PC;
        o_dec.b_sel   = OPB_IMM;
        o_dec.imm_sel = IMM_U;
        o_dec.rd_we   = w_rd_nz;
      end
      OPC_BRANCH: begin
        o_dec.branch  = 1'b1;
        o_dec.imm_sel = IMM_B;
        case (w_f3)
          F3_BEQ:  o_dec.op = ALU_EQ;
          F3_BNE:  o_dec.op = ALU_NE;
          F3_BLT:  o_dec.op = ALU_SLT;
          F3_BGE:  o_dec.op = ALU_GES;
          F3_BLTU: o_dec.op = ALU_SLTU;
          F3_BGEU: o_dec.op = ALU_GEU;
          default: o_dec.illegal = 1'b1;
        endcase
      end
      default: o_dec.illegal = 1'b1;
    endcase
    // Illegal instructions flow through as a harmless no-write ADD
    if (o_dec.illegal) begin
      o_dec.op     = ALU_ADD;
      o_dec.rd_we  = 1'b0;
      o_dec.branch = 1'b0;
    end
  end

  always_comb begin
    o_imm = w_imm_i;
    case (o_dec.imm_sel)
      IMM_SHAMT: o_imm = w_imm_sh;
      IMM_U:     o_imm = w_imm_u;
      IMM_B:     o_imm = o_imm_b;
      default:   o_imm = w_imm_i;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: valid/ready intake, operand selection and one-slot register toward execute.
module id_stage
  import toothless_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [DATA_WIDTH-1:0]     instr_i,
  input  logic [DATA_WIDTH-1:0]     pc_i,
  output logic [REG_ADDR_WIDTH-1:0] rs1_addr_o,
  output logic [REG_ADDR_WIDTH-1:0] rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]     rs1_data_i,
  input  logic [DATA_WIDTH-1:0]     rs2_data_i,
  input  logic                      flush_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output alu_opcode_e               alu_operator_o,
  output logic [DATA_WIDTH-1:0]     alu_operand_a_o,
  output logic [DATA_WIDTH-1:0]     alu_operand_b_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
  output logic                      rd_we_o,
  output logic                      branch_o,
  output logic [DATA_WIDTH-1:0]     branch_target_o,
  output logic                      illegal_instr_o
);

  id_dec_t               w_dec;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0] w_imm_b;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic                  w_accept;

  logic                      r_valid;
  alu_opcode_e               r_op;
  logic [DATA_WIDTH-1:0]     r_op_a;
  logic [DATA_WIDTH-1:0]     r_op_b;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_rd_we;
  logic                      r_branch;
  logic [DATA_WIDTH-1:0]     r_target;
  logic                      r_illegal;

  id_decoder u_dec (
    .i_instr (instr_i),
    .o_dec   (w_dec),
    .o_imm   (w_imm),
    .o_imm_b (w_imm_b)
  );

  assign rs1_addr_o    = REG_ADDR_WIDTH'(instr_i[19:15]);
  assign rs2_addr_o    = REG_ADDR_WIDTH'(instr_i[24:20]);
  assign instr_ready_o = !r_valid || ex_ready_i;
  assign w_accept      = instr_valid_i && instr_ready_o;

  always_comb begin
    w_op_a = rs1_data_i;
    w_op_b = rs2_data_i;
    case (w_dec.a_sel)
      OPA_ZERO: w_op_a = '0;
      OPA_PC:   w_op_a = pc_i;
      default:  w_op_a = rs1_data_i;
    endcase
    case (w_dec.b_sel)
      OPB_RS2_SHAMT: w_op_b = {{(DATA_WIDTH-5){1'b0}}, rs2_data_i[4:0]};
      OPB_IMM:       w_op_b = w_imm;
      default:       w_op_b = rs2_data_i;
    endcase
  end

  // Flush wins over accept; payload only moves on a surviving accept so a stalled slot holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_op      <= ALU_ADD;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd      <= '0;
      r_rd_we   <= 1'b0;
      r_branch  <= 1'b0;
      r_target  <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (flush_i)         r_valid <= 1'b0;
      else if (w_accept)   r_valid <= 1'b1;
      else if (ex_ready_i) r_valid <= 1'b0;
      if (w_accept && !flush_i) begin
        r_op      <= w_dec.op;
        r_op_a    <= w_op_a;
        r_op_b    <= w_op_b;
        r_rd      <= REG_ADDR_WIDTH'(instr_i[11:7]);
        r_rd_we   <= w_dec.rd_we;
        r_branch  <= w_dec.branch;
        r_target  <= pc_i + w_imm_b;
        r_illegal <= w_dec.illegal;
      end
    end
  end

  assign ex_valid_o      = r_valid;
  assign alu_operator_o  = r_op;
  assign alu_operand_a_o = r_op_a;
  assign alu_operand_b_o = r_op_b;
  assign rd_addr_o       = r_rd;
  assign rd_we_o         = r_rd_we;
  assign branch_o        = r_branch;
  assign branch_target_o = r_target;
  assign illegal_instr_o = r_illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized checks of id_stage against a mnemonic-level reference model.
module tb_id_stage;
  import toothless_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic        flush_i = 1'b0;
  logic        ex_valid_o;
  logic        ex_ready_i = 1'b1;
  alu_opcode_e alu_operator_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o, branch_o, illegal_instr_o;
  logic [31:0] branch_target_o;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
    .alu_operator_o(alu_operator_o),
    .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
    .rd_addr_o(rd_addr_o), .rd_we_o(rd_we_o), .branch_o(branch_o),
    .branch_target_o(branch_target_o), .illegal_instr_o(illegal_instr_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  typedef struct {
    alu_opcode_e op;
    logic [31:0] a, b, target;
    logic [4:0]  rd;
    logic        rd_we, branch, illegal;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Reference: what each RV32I mnemonic means, written from the ISA rules
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    alu_opcode_e arith[8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                              ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    alu_opcode_e br[8]    = '{ALU_EQ, ALU_NE, ALU_ADD, ALU_ADD,
                              ALU_SLT, ALU_GES, ALU_SLTU, ALU_GEU};
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    bit is_shift = (f3 == 1) || (f3 == 5);
    logic [31:0] imm_i = 32'($signed(ins[31:20]));
    logic [31:0] imm_u = ins & 32'hFFFF_F000;
    logic [31:0] imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    e.op = ALU_ADD; e.a = r1; e.b = r2; e.rd = ins[11:7];
    e.rd_we = 1'b0; e.branch = 1'b0; e.illegal = 1'b0;
    e.target = pc + imm_b;
    case (ins[6:0])
      7'h33: begin
        e.illegal = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
        e.op = (f7 == 32) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : arith[f3];
        e.b  = is_shift ? r2 % 32 : r2;
      end
      7'h13: begin
        e.illegal = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 32);
        e.op = (f3 == 5 && f7 == 32) ? ALU_SRA : arith[f3];
        e.b  = is_shift ? 32'(ins[24:20]) : imm_i;
      end
      7'h37: begin e.a = 0;  e.b = imm_u; end
      7'h17: begin e.a = pc; e.b = imm_u; end
      7'h63: begin
        e.illegal = (f3 == 2) || (f3 == 3);
        e.op = br[f3];
        e.branch = 1'b1;
      end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin
      e.op = ALU_ADD; e.branch = 1'b0;
    end else if (!e.branch) begin
      e.rd_we = (e.rd != 0);
    end
    return e;
  endfunction

  task automatic check_slot(input string tag, input exp_t e);
    check({tag, ".valid"},   32'(ex_valid_o),      32'd1);
    check({tag, ".illegal"}, 32'(illegal_instr_o), 32'(e.illegal));
    check({tag, ".op"},      32'(alu_operator_o),  32'(e.op));
    check({tag, ".rd_we"},   32'(rd_we_o),         32'(e.rd_we));
    check({tag, ".branch"},  32'(branch_o),        32'(e.branch));
    check({tag, ".target"},  branch_target_o,      e.target);
    if (!e.illegal) begin
      check({tag, ".a"}, alu_operand_a_o, e.a);
      check({tag, ".b"}, alu_operand_b_o, e.b);
      if (!e.branch) check({tag, ".rd"}, 32'(rd_addr_o), 32'(e.rd));
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    instr_valid_i = 1'b1; instr_i = ins; pc_i = pc;
    rs1_data_i = r1; rs2_data_i = r2;
  endtask

  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, output exp_t e);
    drive(ins, pc, r1, r2);
    e = model(ins, pc, r1, r2);
    @(posedge clk); #1;
    check_slot(tag, e);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    logic [6:0]  f7;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 6))
      0:       return {f7, w[24:7], OPC_OP};
      1:       return {f7, w[24:7], OPC_OP_IMM};
      2:       return {w[31:7], OPC_LUI};
      3:       return {w[31:7], OPC_AUIPC};
      4:       return {f7, w[24:7], OPC_BRANCH};
      5:       return {w[31:7], OPC_OP_IMM};
      default: return w;
    endcase
  endfunction

  initial begin
    exp_t e, e_hold, e_slot;
    bit   exp_valid;

    // Reset state
    #2;
    check("rst.valid",  32'(ex_valid_o),     32'd0);
    check("rst.op",     32'(alu_operator_o), 32'(ALU_ADD));
    check("rst.a",      alu_operand_a_o,     32'd0);
    check("rst.rd_we",  32'(rd_we_o),        32'd0);
    check("rst.ready",  32'(instr_ready_o),  32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADDI x5,x1,-3
    drive(32'hFFD08293, 32'h0, 32'd10, 32'h55);
    #1;
    check("addi.rs1_addr", 32'(rs1_addr_o), 32'd1);
    issue("addi", 32'hFFD08293, 32'h0, 32'd10, 32'h55, e);
    check("addi.b_lit", alu_operand_b_o, 32'hFFFF_FFFD);

    // Back-to-back SUB, SRAI, SLL
    issue("sub",  32'h402081B3, 32'h4, 32'd7, 32'd9, e);
    check("sub.op_lit", 32'(alu_operator_o), 32'(ALU_SUB));
    issue("srai", 32'h4043D313, 32'h8, 32'hF000_0000, 32'h1, e);
    check("srai.b_lit", alu_operand_b_o, 32'd4);
    issue("sll",  32'h00209233, 32'hC, 32'h1, 32'h123, e);
    check("sll.b_lit", alu_operand_b_o, 32'd3);

    // LUI / AUIPC
    issue("lui",   32'h123450B7, 32'h10, 32'hDEAD, 32'hBEEF, e);
    check("lui.b_lit", alu_operand_b_o, 32'h1234_5000);
    issue("auipc", 32'h12345097, 32'h100, 32'hDEAD, 32'hBEEF, e);
    check("auipc.a_lit", alu_operand_a_o, 32'h100);

    // BEQ x1,x2,+8 at 0x40
    issue("beq", 32'h00208463, 32'h40, 32'd5, 32'd5, e_hold);
    check("beq.target_lit", branch_target_o, 32'h48);

    // Stall: slot held while execute is not ready
    ex_ready_i = 1'b0;
    drive(32'h002083B3, 32'h44, 32'd3, 32'd4);
    #1;
    check("stall.ready", 32'(instr_ready_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_slot("stall.hold", e_hold);
    end
    ex_ready_i = 1'b1;
    #1;
    check("stall.ready_up", 32'(instr_ready_o), 32'd1);
    issue("stall.add", 32'h002083B3, 32'h44, 32'd3, 32'd4, e);

    // All-ones word is undecodable
    issue("ill", 32'hFFFF_FFFF, 32'h48, 32'h1, 32'h2, e);
    check("ill.lit", 32'(illegal_instr_o), 32'd1);

    // Flush with accept in the same cycle
    drive(32'hFFD08293, 32'h4C, 32'd1, 32'd2);
    flush_i = 1'b1;
    @(posedge clk); #1;
    check("flush.valid", 32'(ex_valid_o), 32'd0);
    flush_i = 1'b0;

    // Asynchronous reset mid-stream
    issue("pre_rst", 32'h123450B7, 32'h50, 32'h0, 32'h0, e);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", 32'(ex_valid_o),     32'd0);
    check("arst.op",    32'(alu_operator_o), 32'(ALU_ADD));
    check("arst.b",     alu_operand_b_o,     32'd0);
    instr_valid_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized traffic with backpressure and flushes
    exp_valid = 1'b0;
    e_slot    = model(32'h0, 32'h0, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      logic v, rdy, fl, acc;
      logic [31:0] ins, pc, r1, r2;
      v = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 15) == 0);
      ins = gen_instr(); pc = $urandom & 32'hFFFF_FFFC; r1 = $urandom; r2 = $urandom;
      drive(ins, pc, r1, r2);
      instr_valid_i = v; ex_ready_i = rdy; flush_i = fl;
      #1;
      check("rnd.ready", 32'(instr_ready_o), 32'(!exp_valid || rdy));
      acc = v && (!exp_valid || rdy);
      @(posedge clk); #1;
      if (fl) exp_valid = 1'b0;
      else if (acc) begin exp_valid = 1'b1; e_slot = model(ins, pc, r1, r2); end
      else if (rdy) exp_valid = 1'b0;
      check("rnd.valid", 32'(ex_valid_o), 32'(exp_valid));
      if (exp_valid) check_slot("rnd", e_slot);
    end
    instr_valid_i = 1'b0; flush_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
